// File: rtl/twenty48_pkg.sv
// ============================================================================
// twenty48_pkg : shared move codes and direction-button bit indices.
// Rev 1.0
// ============================================================================
`default_nettype none

package twenty48_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;

endpackage

`default_nettype wire

// File: rtl/move_fifo.sv
// ============================================================================
// move_fifo : DEPTH x 2-bit fall-through FIFO. A push is accepted when full
// only if the head is popped in the same cycle. Reading an empty FIFO returns 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module move_fifo
  import twenty48_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  dir_t             push_data,
  input  logic             pop,
  output dir_t             rd_data,
  output logic             accepted,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  dir_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_ok   = pop & ~empty;
  assign accepted = push & (~full | pop_ok);
  assign rd_data  = empty ? DIR_UP : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (accepted) wr_ptr <= wr_ptr + PTR_W'(1);
      if (accepted && !pop_ok)      count <= count + (PTR_W+1)'(1);
      else if (!accepted && pop_ok) count <= count - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible past the pointers.
  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/move_queue.sv
// ============================================================================
// move_queue : edge-detects direction presses, priority-encodes them into move
// codes and queues them. Optional macro MOVE_QUEUE_COALESCE_EN drops an event
// equal to the queued tail code. Rev 1.0
// ============================================================================
`default_nettype none

module move_queue
  import twenty48_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       press,
  output logic             move_valid,
  output logic [1:0]       move_dir,
  input  logic             move_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  logic [3:0] press_q;
  logic [3:0] edges;
  logic       evt;
  dir_t       code;
  logic       push_req;
  logic       pop;
  logic       accepted;
  logic       full;
  logic       empty;
  dir_t       head;

  assign edges = press & ~press_q;
  assign evt   = |edges;

  // Lowest bit wins; losing edges are dropped without flagging overflow.
  always_comb begin
    code = DIR_UP;
    if (edges[BTN_UP])         code = DIR_UP;
    else if (edges[BTN_RIGHT]) code = DIR_RIGHT;
    else if (edges[BTN_DOWN])  code = DIR_DOWN;
    else if (edges[BTN_LEFT])  code = DIR_LEFT;
  end

`ifdef MOVE_QUEUE_COALESCE_EN
  dir_t last_code;

  assign push_req = evt & ~((count != '0) && (code == last_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_code <= DIR_UP;
    else if (accepted) last_code <= code;
  end
`else
  assign push_req = evt;
`endif

  assign move_valid = ~empty;
  assign move_dir   = head;
  assign pop        = move_valid & move_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q  <= '0;
      overflow <= 1'b0;
    end else begin
      press_q  <= press;
      overflow <= push_req & full & ~pop;
    end
  end

  move_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (code),
    .pop       (pop),
    .rd_data   (head),
    .accepted  (accepted),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_move_queue.sv
// ============================================================================
// tb_move_queue : directed and random stimulus for move_queue, checked against
// a queue-based model every cycle plus hand-computed expectations.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_move_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] press = 4'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  move_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .press      (press),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .count      (count),
    .overflow   (overflow)
  );

  // Model: queue of codes, previous press levels, overflow flag.
  int         mq[$];
  logic [3:0] m_prev;
  bit         m_ovf;
  int         m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_prev = 4'b0;
      m_ovf  = 1'b0;
      m_last = 0;
    end else begin
      logic [3:0] e;
      bit do_pop, want;
      int d;
      e      = press & ~m_prev;
      m_prev = press;
      do_pop = (mq.size() > 0) && move_ready;
      want   = (e != 4'b0);
      d      = 0;
      for (int b = 3; b >= 0; b--) if (e[b]) d = b;
`ifdef MOVE_QUEUE_COALESCE_EN
      if (want && mq.size() > 0 && d == m_last) want = 0;
`endif
      m_ovf = 1'b0;
      if (want && mq.size() == DEPTH && !do_pop) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (want && !m_ovf) begin
        mq.push_back(d);
        m_last = d;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int exp_dir;
      exp_dir = (mq.size() > 0) ? mq[0] : 0;
      total++;
      if (move_valid !== (mq.size() > 0) || count !== 3'(mq.size()) ||
          overflow !== m_ovf || int'(move_dir) != exp_dir || $isunknown(move_dir)) begin
        bad++;
        $display("FAIL model t=%0t valid=%b dir=%0d count=%0d ovf=%b required valid=%b dir=%0d count=%0d ovf=%b",
                 $time, move_valid, move_dir, count, overflow,
                 mq.size() > 0, exp_dir, mq.size(), m_ovf);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    press = 4'b0001 << d;
    step();
    press = 4'b0;
    step();
  endtask

  task automatic drain();
    move_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) step();
    move_ready = 1'b0;
  endtask

  int hs;
  int exp4 [4];
  int exp5 [4];

  initial begin
    exp4 = '{0, 1, 2, 3};
    exp5 = '{2, 1, 0, 1};

    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_valid", move_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_dir", move_dir, 0);
    for (int i = 0; i < 4; i++) step();

    // One-cycle pulse on right
    press = 4'b0010;
    step();
    press = 4'b0;
    chk("pulse_valid", move_valid, 1);
    chk("pulse_dir", move_dir, 1);
    chk("pulse_count", count, 1);
    step();
    chk("pulse_dir_stable", move_dir, 1);
    drain();
    chk("pulse_drained", count, 0);

    // Held-high up button with consumer ready
    hs = 0;
    press = 4'b0001;
    move_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (move_valid && move_ready) begin
        hs++;
        chk("held_dir", move_dir, 0);
      end
      step();
    end
    chk("held_handshakes", hs, 1);
    chk("held_count", count, 0);
    press = 4'b0;
    move_ready = 1'b0;
    step();

    // Simultaneous down+left edges
    press = 4'b1100;
    step();
    press = 4'b0;
    chk("simul_count", count, 1);
    chk("simul_dir", move_dir, 2);
    chk("simul_ovf", overflow, 0);
    step();
    chk("simul_ovf2", overflow, 0);
    drain();

    // Fill past full
    for (int d = 0; d < 4; d++) pulse(d);
    chk("full_count", count, 4);
    press = 4'b0001;
    step();
    press = 4'b0;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 4);
    step();
    chk("ovf_cleared", overflow, 0);
    move_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", move_dir, exp4[i]);
      step();
    end
    move_ready = 1'b0;
    chk("drain_empty", move_valid, 0);
    step();

    // Push into full queue with simultaneous pop
    for (int d = 3; d >= 0; d--) pulse(d);
    chk("full2_count", count, 4);
    press = 4'b0010;
    move_ready = 1'b1;
    step();
    press = 4'b0;
    move_ready = 1'b0;
    chk("pushpop_count", count, 4);
    chk("pushpop_ovf", overflow, 0);
    move_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pushpop_order", move_dir, exp5[i]);
      step();
    end
    move_ready = 1'b0;
    step();

    // Asynchronous reset mid-queue
    for (int d = 0; d < 3; d++) pulse(d);
    chk("pre_rst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", move_valid, 0);
    chk("async_rst_count", count, 0);
    step();
    rst = 1'b0;
    step();

    // Two identical left pulses
    pulse(3);
    pulse(3);
`ifdef MOVE_QUEUE_COALESCE_EN
    chk("repeat_count", count, 1);
`else
    chk("repeat_count", count, 2);
`endif
    drain();

    // Random presses and ready, checked by the model
    for (int i = 0; i < 400; i++) begin
      press = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      move_ready = $urandom_range(0, 2) == 0;
      step();
    end
    press = 4'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/move_queue.md
Name: move_queue

Overview:
- Sits downstream of the four direction-button debouncers. It consumes their `pressed` outputs and turns each new press into a 2-bit move code.
- Move codes are buffered in a small FIFO. The game board logic drains them through a valid/ready handshake.
- A press that arrives while the board is still sliding tiles is queued, not lost. Presses are only dropped (and flagged) on overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- press  input  4  debounced press levels/pulses; bit0=up, bit1=right, bit2=down, bit3=left.
- move_valid  output  1  head entry available.
- move_dir  output  2  head move code: 0=up, 1=right, 2=down, 3=left.
- move_ready  input  1  consumer accepts head when move_valid & move_ready.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: an event was dropped because the queue was full.

Behaviour:
- Reset: rst high asynchronously clears FIFO pointers, count=0, press_q=0, overflow=0. The consequences follow:
  - move_valid=0 and move_dir=0 while empty.
  - Entries in flight are discarded.
  - A press bit already high at reset release produces an event on the first clock after release, because press_q=0.
- Edge detect: press_q registers press each cycle. edge = press & ~press_q.
  - A held-high input yields exactly one event.
  - A single-cycle debouncer pulse yields one event.
- Simultaneous edges: fixed priority, lowest bit index wins (up > right > down > left). The other edges in that cycle are discarded silently; they do not raise overflow.
- Push: event in cycle N and (count<DEPTH or pop in cycle N) → code written at tail on the posedge ending N.
  - Visible at the head (if the queue was empty) from cycle N+1: move_valid=1.
  - Latency from the press rising to move_valid is 1 cycle.
- Pop: move_valid & move_ready → head advances at posedge.
  - move_dir is fall-through from mem[rd_ptr] and stays stable while move_valid=1 and ready=0.
- Full: count==DEPTH with event and no pop → event dropped; overflow=1 for the next cycle only. Full with event and simultaneous pop → push accepted, count stays DEPTH.
- Empty: move_ready ignored. A push and a "pop" in the same cycle on an empty queue is a push only (no bypass).
- Pointers wrap modulo DEPTH. count = push − pop each cycle, never exceeding DEPTH or dropping below 0.
- move_ready may toggle arbitrarily. move_valid never drops without a pop, except on reset.

Optional Feature:
- Macro MOVE_QUEUE_COALESCE_EN.
- Defined: an event whose code equals the most recently accepted (tail) code while count>0 is discarded, with no overflow. This suppresses repeated identical moves that are still queued.
- Undefined: every event follows the push rules above. The comparison logic and last-code register are absent.

Decomposition:
- Shared package twenty48_pkg:
  - DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT 2-bit constants.
  - dir_t typedef.
  - Button bit-index constants, also used by the board logic.
- One sub-module, move_fifo: a generic DEPTH×2 fall-through FIFO with push/pop/full/empty/count.
- move_queue keeps the edge detect, priority encode, overflow pulse and optional coalescing.

Test Plan:
- Reset, then a press[1] pulse of 1 cycle at cycle 5 → move_valid=1, move_dir=1 at cycle 6; count=1.
- press[0] held high 100 cycles with move_ready=1 → exactly one handshake (dir 0); count returns to 0.
- press=4'b1100 rising together, move_ready=0 → one entry only, dir 2, overflow stays 0.
- With move_ready=0, send 5 distinct-cycle pulses (dirs 0,1,2,3,0) at DEPTH=4 → count=4, overflow pulses once after the 5th. Then draining yields 0,1,2,3.
- Full queue with a pulse and move_ready=1 in the same cycle → count stays 4; the new code appears as the last drained entry; no overflow.
- Assert rst mid-queue (count=3) → move_valid=0 and count=0 immediately, without waiting for clk. With MOVE_QUEUE_COALESCE_EN, two dir-3 pulses while ready=0 → count=1.
